// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the variable-latency instruction memory (slave).
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: drives PC mux select / PC write,
// runs the req/ack handshake with instruction memory, presents one fetched
// instruction at a time to decode, and handles taken-branch redirects
// (including a redirect that abandons an outstanding request).
module fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TO_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic              branch_taken,
  input  logic              stall,
  fetch_ctrl_if.master      mem,
  output logic              pc_write,
  output logic              pc_source,
  output logic              flush,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fetch_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  localparam logic [TO_W-1:0] TO_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [TO_W-1:0]   to_cnt;
  logic              branch;
  logic              waiting;
  logic              accept;

  // Redirect is masked while reset is held so every output reads 0 in reset.
  assign branch  = branch_taken & ~reset;
  assign waiting = (state_q == REQ) || (state_q == DRAIN);
  assign accept  = (state_q == REQ) && mem.mem_ack && !branch;

  // State register, asynchronously forced to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a taken branch overrides stall and ack handling.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (branch)            state_d = mem.mem_ack ? REQ : DRAIN;
        else if (mem.mem_ack)  state_d = HOLD;
        else                   state_d = REQ;
      end
      HOLD: begin
        if (branch || !stall)  state_d = REQ;
        else                   state_d = HOLD;
      end
      DRAIN: begin
        if (mem.mem_ack)       state_d = REQ;
        else                   state_d = DRAIN;
      end
      default:               state_d = IDLE;
    endcase
  end

  // Combinational outputs: memory request and PC control.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_addr = '0;
    pc_write     = 1'b0;
    pc_source    = 1'b0;
    flush        = 1'b0;
    case (state_q)
      REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_current;
        if (mem.mem_ack) pc_write = 1'b1;
      end
      DRAIN: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = addr_q;
      end
      default: ;
    endcase
    if (branch) begin
      pc_write  = 1'b1;
      pc_source = 1'b1;
      flush     = 1'b1;
    end
  end

  // Fetched-instruction register toward decode and abandoned-request address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      addr_q   <= '0;
    end else begin
      if (state_q == REQ) addr_q <= pc_current;
      if (branch_taken) begin
        if_valid <= 1'b0;
      end else if (accept) begin
        if_valid <= 1'b1;
        if_instr <= mem.mem_rdata;
        if_pc    <= pc_current;
      end else if (state_q == HOLD && !stall) begin
        if_valid <= 1'b0;
      end
    end
  end

  // Wait-cycle counter; the error flag is set on the edge the count reaches max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else if (waiting && !mem.mem_ack) begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      if (to_cnt >= TO_MAX - 1'b1) fetch_timeout <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of presented instructions.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        branch_taken, stall;
  logic        pc_write, pc_source, flush;
  logic        if_valid, fetch_timeout;
  logic [31:0] if_instr, if_pc;
  logic [31:0] br_target;
  logic [31:0] pc_reg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;
  fetch_t sb[$];

  fetch_ctrl_if #(.ADDR_W(32)) mem_if ();

  fetch_ctrl #(.ADDR_W(32), .TO_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_current   (pc_current),
    .branch_taken (branch_taken),
    .stall        (stall),
    .mem          (mem_if.master),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .flush        (flush),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  // Memory returns a recognisable word derived from the requested address.
  assign mem_if.mem_rdata = 32'hC0DE_0000 | {16'h0000, mem_if.mem_addr[15:0]};

  // IF-stage PC register model.
  always @(posedge clk or posedge reset) begin
    if (reset)         pc_reg <= 32'h0;
    else if (pc_write) pc_reg <= pc_source ? br_target : pc_reg + 32'd4;
  end
  assign pc_current = pc_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, return before the next one.
  task automatic cyc(input logic br, input logic st, input logic ack, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    branch_taken   = br;
    stall          = st;
    mem_if.mem_ack = ack;
    br_target      = tgt;
    #3;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    fetch_t f;
    f.pc    = pc;
    f.instr = instr;
    sb.push_back(f);
  endtask

  // Monitor: every newly presented instruction is matched against the scoreboard.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (if_valid === 1'b1 && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_if_valid actual_pc=%h actual_instr=%h expected=none", if_pc, if_instr);
      end else begin
        fetch_t e;
        e = sb.pop_front();
        chk("sb_if_pc", if_pc, e.pc);
        chk("sb_if_instr", if_instr, e.instr);
      end
    end
    prev_v = (if_valid === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; branch_taken = 1'b0; stall = 1'b0;
    mem_if.mem_ack = 1'b0; br_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_timeout", {31'b0, fetch_timeout}, 32'd0);
    reset = 1'b0;
    #3;
    chk("idle_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("idle_pc_write", {31'b0, pc_write}, 32'd0);

    // Back-to-back fetches with ack tied high.
    cyc(0, 0, 1, 0);
    chk("f0_mem_req", {31'b0, mem_if.mem_req}, 32'd1);
    chk("f0_mem_addr", mem_if.mem_addr, 32'h0);
    chk("f0_pc_write", {31'b0, pc_write}, 32'd1);
    chk("f0_pc_source", {31'b0, pc_source}, 32'd0);
    chk("f0_if_valid", {31'b0, if_valid}, 32'd0);
    push(32'h0, 32'hC0DE_0000);
    cyc(0, 0, 1, 0);
    chk("h0_if_valid", {31'b0, if_valid}, 32'd1);
    chk("h0_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("h0_pc_write", {31'b0, pc_write}, 32'd0);
    cyc(0, 0, 1, 0);
    chk("f4_mem_addr", mem_if.mem_addr, 32'h4);
    chk("f4_pc_write", {31'b0, pc_write}, 32'd1);
    push(32'h4, 32'hC0DE_0004);
    cyc(0, 0, 1, 0);

    // Stall for three cycles in HOLD at pc 0x8.
    cyc(0, 0, 1, 0);
    chk("f8_mem_addr", mem_if.mem_addr, 32'h8);
    push(32'h8, 32'hC0DE_0008);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0);
      chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_if_instr", if_instr, 32'hC0DE_0008);
      chk("stall_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
      chk("stall_pc_write", {31'b0, pc_write}, 32'd0);
    end
    cyc(0, 0, 1, 0);
    chk("unstall_if_valid", {31'b0, if_valid}, 32'd1);
    chk("unstall_if_pc", if_pc, 32'h8);
    cyc(0, 0, 1, 0);
    chk("fC_mem_addr", mem_if.mem_addr, 32'hC);
    chk("fC_if_valid", {31'b0, if_valid}, 32'd0);
    push(32'hC, 32'hC0DE_000C);
    cyc(0, 0, 1, 0);

    // Branch in REQ with the ack arriving four cycles later.
    cyc(1, 0, 0, 32'h100);
    chk("brq_flush", {31'b0, flush}, 32'd1);
    chk("brq_pc_write", {31'b0, pc_write}, 32'd1);
    chk("brq_pc_source", {31'b0, pc_source}, 32'd1);
    chk("brq_mem_addr", mem_if.mem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("drain_mem_req", {31'b0, mem_if.mem_req}, 32'd1);
      chk("drain_mem_addr", mem_if.mem_addr, 32'h10);
      chk("drain_flush", {31'b0, flush}, 32'd0);
      chk("drain_pc_write", {31'b0, pc_write}, 32'd0);
      chk("drain_if_valid", {31'b0, if_valid}, 32'd0);
    end
    cyc(0, 0, 1, 0);
    chk("drain_ack_addr", mem_if.mem_addr, 32'h10);
    chk("drain_ack_pc_write", {31'b0, pc_write}, 32'd0);
    cyc(0, 0, 1, 0);
    chk("tgt_if_valid", {31'b0, if_valid}, 32'd0);
    chk("tgt_mem_addr", mem_if.mem_addr, 32'h100);
    chk("tgt_pc_write", {31'b0, pc_write}, 32'd1);
    push(32'h100, 32'hC0DE_0100);
    cyc(0, 0, 1, 0);

    // Branch coinciding with ack in REQ: data dropped, straight back to REQ.
    cyc(1, 0, 1, 32'h200);
    chk("brack_mem_addr", mem_if.mem_addr, 32'h104);
    chk("brack_flush", {31'b0, flush}, 32'd1);
    chk("brack_pc_source", {31'b0, pc_source}, 32'd1);
    cyc(0, 0, 1, 0);
    chk("brack_if_valid", {31'b0, if_valid}, 32'd0);
    chk("brack_flush_once", {31'b0, flush}, 32'd0);
    chk("brack_mem_addr2", mem_if.mem_addr, 32'h200);
    push(32'h200, 32'hC0DE_0200);

    // Branch beats stall in HOLD.
    cyc(1, 1, 0, 32'h300);
    chk("brhold_if_valid", {31'b0, if_valid}, 32'd1);
    chk("brhold_flush", {31'b0, flush}, 32'd1);
    chk("brhold_pc_source", {31'b0, pc_source}, 32'd1);
    chk("brhold_mem_req", {31'b0, mem_if.mem_req}, 32'd0);

    // Ack withheld: error flag rises after 15 waiting cycles and is sticky.
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0, 0);
      chk("to_if_valid", {31'b0, if_valid}, 32'd0);
      chk("to_mem_addr", mem_if.mem_addr, 32'h300);
      chk("to_flag", {31'b0, fetch_timeout}, (k >= 16) ? 32'd1 : 32'd0);
    end
    cyc(0, 0, 1, 0);
    chk("to_after_ack", {31'b0, fetch_timeout}, 32'd1);
    push(32'h300, 32'hC0DE_0300);
    cyc(0, 0, 0, 0);
    chk("to_sticky", {31'b0, fetch_timeout}, 32'd1);

    // Reset asserted while draining an abandoned request.
    cyc(1, 0, 0, 32'h400);
    cyc(0, 0, 0, 0);
    chk("pre_rst_mem_addr", mem_if.mem_addr, 32'h304);
    #1 reset = 1'b1;
    #1;
    chk("drst_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("drst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("drst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("drst_timeout", {31'b0, fetch_timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_if.mem_ack = 1'b1;
    #3;
    chk("late_ack_mem_req", {31'b0, mem_if.mem_req}, 32'd0);
    chk("late_ack_pc_write", {31'b0, pc_write}, 32'd0);
    chk("late_ack_if_valid", {31'b0, if_valid}, 32'd0);
    cyc(0, 0, 1, 0);
    chk("post_rst_mem_addr", mem_if.mem_addr, 32'h0);
    push(32'h0, 32'hC0DE_0000);
    cyc(0, 0, 0, 0);
    chk("post_rst_if_valid", {31'b0, if_valid}, 32'd1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage. It drives the PC mux select and PC write-enable of the IF datapath. It runs a req/ack handshake with a variable-latency instruction memory, then presents one fetched instruction at a time to decode under a stall signal. It also handles taken-branch redirects, including a redirect that arrives while a memory request is outstanding.

Parameters:
ADDR_W, 32, width of PC and memory address
TO_W, 4, width of the wait-cycle timeout counter; timeout fires at 2^TO_W-1 cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_current  in  ADDR_W  current PC from the IF-stage register
branch_taken  in  1  resolved taken branch this cycle
stall  in  1  decode cannot accept the presented instruction
mem_req  out  1  instruction memory request
mem_addr  out  ADDR_W  request address
mem_ack  in  1  mem_rdata valid this cycle
mem_rdata  in  32  instruction word
pc_write  out  1  PC register enable
pc_source  out  1  PC mux select: 0 = pc+4, 1 = branch target
flush  out  1  kill in-flight/presented instruction
if_valid  out  1  if_instr/if_pc valid
if_instr  out  32  latched instruction
if_pc  out  ADDR_W  PC of if_instr
fetch_timeout  out  1  sticky wait-timeout error

Behaviour:
- Reset: clk single clock; reset asynchronous, active-high. Reset forces state IDLE immediately, including mid-request. All outputs are 0, as are if_instr, if_pc, addr_q and the timeout counter.
- Registered outputs: if_valid, if_instr, if_pc, fetch_timeout.
- Combinational outputs (from state and inputs): mem_req, mem_addr, pc_write, pc_source, flush.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: no request. Next cycle goes to REQ.
- REQ:
  - mem_req=1 and mem_addr=pc_current. pc_current is stable because the PC only moves on exit from REQ. addr_q <= pc_current every REQ cycle.
  - mem_ack and no branch: pc_write=1, pc_source=0 in the same cycle. At the edge, if_instr<=mem_rdata, if_pc<=pc_current, if_valid<=1, state goes to HOLD. Minimum fetch latency is 1 cycle from mem_req to if_valid.
- HOLD:
  - if_valid=1 and no request.
  - !stall: instruction is consumed at this edge; if_valid<=0 and state goes to REQ.
  - stall: remain in HOLD with outputs unchanged.
- DRAIN:
  - mem_req=1 and mem_addr=addr_q, holding the abandoned request until it acks.
  - On mem_ack the data is discarded and state goes to REQ.
- branch_taken, any state, has priority over everything else:
  - Same cycle: pc_write=1, pc_source=1, flush=1 (one cycle per branch cycle). At the edge, if_valid<=0.
  - From IDLE or HOLD: go to REQ. In HOLD a branch beats stall.
  - From REQ without mem_ack: go to DRAIN, because the request is outstanding.
  - From REQ with mem_ack in the same cycle: data discarded, go to REQ.
  - From DRAIN without ack: stay in DRAIN; the PC is rewritten and the latest target wins.
  - From DRAIN with ack: go to REQ.
- pc_write is asserted only in the two cases above: ack in REQ, or branch_taken. pc_source=1 only with branch_taken.
- mem_ack outside REQ/DRAIN is ignored.
- Timeout:
  - The counter increments each REQ/DRAIN cycle without ack and clears on ack or on leaving REQ/DRAIN.
  - On reaching 2^TO_W-1, fetch_timeout<=1 and stays set until reset.
  - The FSM keeps waiting; the counter saturates.

Test Plan:
- Reset, then release with pc_current=0 and mem_ack tied 1, no stall → mem_req in cycle 1 with mem_addr=0. Cycle 2: if_valid=1, if_pc=0, if_instr=mem_rdata. pc_write pulses once per fetch with pc_source=0. mem_req/if_valid alternate each cycle.
- Fetch at pc=0x8 with stall high for 3 cycles in HOLD → if_valid held 3+1 cycles, if_instr stable, no mem_req. The next mem_addr is 0xC after stall drops.
- branch_taken in REQ with mem_ack delayed 4 cycles → same-cycle flush=1, pc_write=1, pc_source=1. mem_addr stays at the old address through DRAIN. The returned data is dropped (if_valid stays 0). The next REQ uses the target PC.
- branch_taken coinciding with mem_ack in REQ, and separately branch with stall=1 in HOLD → no if_valid for the old instruction; next state REQ; flush one cycle.
- mem_ack held low with TO_W=4 → fetch_timeout rises after 15 REQ cycles and stays 1 after the later ack. Reset clears it.
- Assert reset while in DRAIN → immediate mem_req=0, if_valid=0, state IDLE. A late mem_ack after release is ignored.
